// File: rtl/div_by_five_pkg.sv
// Shared definitions for the divisible-by-five datapath: nibble width,
// serializer FSM states and the per-word nibble count helper.
package div_by_five_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  function automatic int unsigned nibble_count(input int unsigned bit_width);
    return bit_width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Word-in / nibble-out handshake bundle for nibble_serializer.
// master = producer/consumer side, slave = serializer side.
interface nibble_serializer_if
  import div_by_five_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
);

  logic [BIT_WIDTH-1:0] in_msg;
  logic                 in_val;
  logic                 in_rdy;
  logic [NIBBLE_W-1:0]  out_nibble;
  logic                 out_first;
  logic                 out_last;
  logic                 out_val;
  logic                 out_rdy;

  modport master (
    output in_msg, in_val, out_rdy,
    input  in_rdy, out_nibble, out_first, out_last, out_val
  );

  modport slave (
    input  in_msg, in_val, out_rdy,
    output in_rdy, out_nibble, out_first, out_last, out_val
  );

endinterface

// File: rtl/nibble_serializer.sv
// Splits a BIT_WIDTH-bit word into LS-first 4-bit nibbles tagged first/last.
// Define NIBBLE_SERIALIZER_SKIP_ZERO_EN to stop after the highest non-zero nibble.
module nibble_serializer
  import div_by_five_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  nibble_serializer_if.slave bus
);

  localparam int unsigned      N        = nibble_count(BIT_WIDTH);
  localparam int unsigned      CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if ((BIT_WIDTH % NIBBLE_W) != 0 || BIT_WIDTH < 8) begin : g_bad_width
      $error("nibble_serializer: BIT_WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  ser_state_e           state_q, state_d;
  logic [BIT_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 send;
  logic                 last_rule;
  logic                 last_c;
  logic                 in_rdy_c;
  logic                 in_xfer;
  logic                 out_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef NIBBLE_SERIALIZER_SKIP_ZERO_EN
  assign last_rule = (cnt_q == CNT_LAST) || (sreg_q[BIT_WIDTH-1:NIBBLE_W] == '0);
`else
  assign last_rule = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    send     = (state_q == SEND);
    last_c   = send && last_rule;
    // in_rdy depends combinationally on out_rdy so a new word can follow the last nibble.
    in_rdy_c = !rst && (!send || (bus.out_rdy && last_c));
    in_xfer  = bus.in_val && in_rdy_c;
    out_xfer = send && bus.out_rdy;

    if (in_xfer) begin
      sreg_d  = bus.in_msg;
      cnt_d   = '0;
      state_d = SEND;
    end else if (out_xfer) begin
      if (last_c) begin
        state_d = IDLE;
      end else begin
        sreg_d = sreg_q >> NIBBLE_W;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_rdy     = in_rdy_c;
  assign bus.out_val    = send;
  assign bus.out_nibble = send ? sreg_q[NIBBLE_W-1:0] : '0;
  assign bus.out_first  = send && (cnt_q == '0);
  assign bus.out_last   = last_c;

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer (BIT_WIDTH=32), either build of
// NIBBLE_SERIALIZER_SKIP_ZERO_EN.
module tb_nibble_serializer;
  import div_by_five_pkg::*;

  localparam int unsigned BW = 32;
  localparam int unsigned N  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serializer_if #(.BIT_WIDTH(BW)) bus ();

  nibble_serializer #(.BIT_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] msg;
    int unsigned exp_len;
  } vec_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       first;
    logic       last;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change after negedge; outputs are sampled 1ns later, well before posedge.
  task automatic drive(input logic v, input logic [31:0] msg, input logic rdy);
    @(negedge clk);
    bus.in_val  = v;
    bus.in_msg  = msg;
    bus.out_rdy = rdy;
    #1;
  endtask

  function automatic logic [3:0] nib(input logic [31:0] w, input int unsigned i);
    logic [31:0] t;
    t = w >> (4 * i);
    return t[3:0];
  endfunction

  // Number of nibbles a word should produce.
  function automatic int unsigned model_len(input logic [31:0] w);
    int unsigned n;
    n = N;
`ifdef NIBBLE_SERIALIZER_SKIP_ZERO_EN
    n = 1;
    for (int unsigned i = 0; i < N; i++)
      if (nib(w, i) != 4'h0) n = i + 1;
`endif
    return n;
  endfunction

  task automatic send_word(input logic [31:0] msg, input int unsigned exp_len);
    drive(1'b1, msg, 1'b1);
    chk("load_in_rdy", bus.in_rdy, 1);
    for (int unsigned k = 0; k < exp_len; k++) begin
      drive(1'b0, '0, 1'b1);
      chk("word_val", bus.out_val, 1);
      chk("word_nib", bus.out_nibble, nib(msg, k));
      chk("word_first", bus.out_first, k == 0);
      chk("word_last", bus.out_last, k == exp_len - 1);
      if (k == exp_len - 1) chk("word_last_in_rdy", bus.in_rdy, 1);
    end
    drive(1'b0, '0, 1'b1);
    chk("word_tail_val", bus.out_val, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    exp_t        q [$];
    logic [31:0] w;
    logic        v, rdy, stalled;
    logic [3:0]  p_nib;
    logic        p_first, p_last;
    int unsigned k, words_sent;

`ifdef NIBBLE_SERIALIZER_SKIP_ZERO_EN
    vecs[0] = '{32'h0000_0019, 2};
    vecs[1] = '{32'h0000_0000, 1};
    vecs[2] = '{32'h8765_4321, 8};
    vecs[3] = '{32'hF000_0000, 8};
    vecs[4] = '{32'h0000_0500, 3};
    vecs[5] = '{32'h0000_0001, 1};
`else
    vecs[0] = '{32'h0000_0019, 8};
    vecs[1] = '{32'h0000_0000, 8};
    vecs[2] = '{32'h8765_4321, 8};
    vecs[3] = '{32'hF000_0000, 8};
    vecs[4] = '{32'h0000_0500, 8};
    vecs[5] = '{32'h0000_0001, 8};
`endif

    bus.in_val  = 1'b0;
    bus.in_msg  = '0;
    bus.out_rdy = 1'b1;

    // Reset state
    drive(1'b1, 32'h1234_5678, 1'b1);
    drive(1'b1, 32'h1234_5678, 1'b1);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_nibble", bus.out_nibble, 0);
    chk("rst_out_first", bus.out_first, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_val = 1'b0;
    #1;
    chk("post_rst_in_rdy", bus.in_rdy, 1);
    chk("post_rst_out_val", bus.out_val, 0);

    // Table-driven words with out_rdy held high
    foreach (vecs[i]) send_word(vecs[i].msg, vecs[i].exp_len);

    // Backpressure: out_rdy 1,0,0,1 repeating
    w = 32'h8765_4321;
    drive(1'b1, w, 1'b1);
    chk("bp_load_in_rdy", bus.in_rdy, 1);
    k = 0;
    stalled = 1'b0;
    p_nib = '0; p_first = 1'b0; p_last = 1'b0;
    for (int unsigned i = 0; i < 40 && k < 8; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      drive(1'b0, '0, rdy);
      chk("bp_val", bus.out_val, 1);
      chk("bp_nib", bus.out_nibble, nib(w, k));
      chk("bp_first", bus.out_first, k == 0);
      chk("bp_last", bus.out_last, k == 7);
      if (stalled) begin
        chk("bp_hold_nib", bus.out_nibble, p_nib);
        chk("bp_hold_first", bus.out_first, p_first);
        chk("bp_hold_last", bus.out_last, p_last);
      end
      p_nib = bus.out_nibble; p_first = bus.out_first; p_last = bus.out_last;
      stalled = !rdy;
      if (rdy) k++;
    end
    chk("bp_count", k, 8);
    drive(1'b0, '0, 1'b1);
    chk("bp_tail_val", bus.out_val, 0);

    // Back-to-back words with in_val held high
    words_sent = 0;
    drive(1'b1, 32'h1111_1111, 1'b1);
    chk("b2b_load_in_rdy", bus.in_rdy, 1);
    if (bus.in_rdy) words_sent = 1;
    for (int unsigned c = 0; c < 16; c++) begin
      v = (words_sent < 2);
      drive(v, 32'h2222_2222, 1'b1);
      chk("b2b_val", bus.out_val, 1);
      chk("b2b_nib", bus.out_nibble, (c < 8) ? 1 : 2);
      chk("b2b_first", bus.out_first, c % 8 == 0);
      chk("b2b_last", bus.out_last, c % 8 == 7);
      if (c == 7) chk("b2b_in_rdy_on_last", bus.in_rdy, 1);
      if (v && bus.in_rdy) words_sent++;
    end
    chk("b2b_words", words_sent, 2);
    drive(1'b0, '0, 1'b1);
    chk("b2b_tail_val", bus.out_val, 0);

    // Reset after the 3rd nibble of a word
    w = 32'hABCD_EF01;
    drive(1'b1, w, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      chk("mid_nib", bus.out_nibble, nib(w, i));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_rdy", bus.in_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_val", bus.out_val, 0);
    chk("mid_rst_in_rdy_after", bus.in_rdy, 1);
    send_word(32'h0000_0005, model_len(32'h0000_0005));

    // Idle
    for (int unsigned i = 0; i < 10; i++) begin
      drive(1'b0, $urandom, 1'($urandom_range(0, 1)));
      chk("idle_val", bus.out_val, 0);
      chk("idle_in_rdy", bus.in_rdy, 1);
    end

    // Random traffic against a nibble-queue reference
    stalled = 1'b0;
    for (int unsigned i = 0; i < 400; i++) begin
      v   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      w   = $urandom >> $urandom_range(0, 31);
      drive(v, w, rdy);
      chk("rnd_val", bus.out_val, q.size() != 0);
      chk("rnd_in_rdy", bus.in_rdy, (q.size() == 0) || (rdy && q[0].last));
      if (q.size() != 0) begin
        chk("rnd_nib", bus.out_nibble, q[0].nib);
        chk("rnd_first", bus.out_first, q[0].first);
        chk("rnd_last", bus.out_last, q[0].last);
      end
      if (stalled) begin
        chk("rnd_hold_val", bus.out_val, 1);
        chk("rnd_hold_nib", bus.out_nibble, p_nib);
        chk("rnd_hold_flags", {bus.out_first, bus.out_last}, {p_first, p_last});
      end
      stalled = bus.out_val && !rdy;
      p_nib = bus.out_nibble; p_first = bus.out_first; p_last = bus.out_last;
      if (bus.out_val && rdy && q.size() != 0) void'(q.pop_front());
      if (v && bus.in_rdy) begin
        k = model_len(w);
        for (int unsigned j = 0; j < k; j++) q.push_back('{nib(w, j), j == 0, j == k - 1});
      end
    end
    for (int unsigned i = 0; i < 20 && q.size() != 0; i++) begin
      drive(1'b0, '0, 1'b1);
      chk("drain_val", bus.out_val, 1);
      chk("drain_nib", bus.out_nibble, q[0].nib);
      chk("drain_flags", {bus.out_first, bus.out_last}, {q[0].first, q[0].last});
      void'(q.pop_front());
    end
    chk("drain_empty", q.size(), 0);
    drive(1'b0, '0, 1'b1);
    chk("drain_tail_val", bus.out_val, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Upstream feeder for the divisible-by-five datapath. It accepts one BIT_WIDTH-bit word over a val/rdy handshake and emits it as a stream of 4-bit nibbles, least-significant nibble first, over a second val/rdy handshake. Each nibble is tagged with first and last flags so the downstream nibble-sum/mod-5 stage can clear and close its accumulation.

## Interface
Parameters:
- BIT_WIDTH, 32, input word width; must be a multiple of 4 and at least 8 (elaboration error otherwise).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_msg  in  BIT_WIDTH  input word.
- in_val  in  1  in_msg valid.
- in_rdy  out  1  block can accept in_msg this cycle.
- out_nibble  out  4  current nibble.
- out_first  out  1  out_nibble is nibble 0 of its word.
- out_last  out  1  out_nibble is the final nibble of its word.
- out_val  out  1  out_nibble/out_first/out_last valid.
- out_rdy  in  1  downstream accepts this cycle.

## Operation
- N = BIT_WIDTH/4 nibbles per word. Internal state: shift register sreg[BIT_WIDTH-1:0], nibble counter cnt (width $clog2(N)), FSM {IDLE, SEND}.
- Handshakes: in transfer when in_val && in_rdy; out transfer when out_val && out_rdy.
- in_rdy = !rst && (state==IDLE || (out transfer && out_last)). Combinational path from out_rdy to in_rdy is intended.
- IDLE: out_val=0. An in transfer loads sreg<=in_msg, cnt<=0, state->SEND.
- SEND: out_val=1, out_nibble=sreg[3:0], out_first=(cnt==0), out_last per rule below.
  - Out transfer, not last: sreg<=sreg>>4 (zero fill), cnt<=cnt+1.
  - Out transfer with last and a simultaneous in transfer: load the new word, cnt<=0, stay in SEND.
  - Out transfer with last and no in transfer: state->IDLE.
- Default last rule: out_last=(cnt==N-1).
- While out_val && !out_rdy: out_nibble, out_first and out_last hold stable. out_val never drops without a transfer.
- in_msg is ignored unless in_rdy. No partial words are emitted.

## Timing
- Reset values: state=IDLE, sreg=0, cnt=0, out_val=0, out_nibble=0, out_first=0, out_last=0. in_rdy=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: in transfer at cycle t gives nibble 0 presented at t+1.
- Throughput: with out_rdy held high, one nibble per cycle. Back-to-back words are separated by no bubble, so a word takes N cycles.
- Reset asserted mid-word: the word is discarded. No further out_val until a new in transfer.
- Single-nibble word (skip-zero mode only): out_first=out_last=1 on the same cycle.

## Configuration
- NIBBLE_SERIALIZER_SKIP_ZERO_EN defined:
  - out_last = (cnt==N-1) || (sreg[BIT_WIDTH-1:4]==0). The word terminates after its highest non-zero nibble.
  - An all-zero word emits exactly one nibble 0 with first and last both set.
  - The downstream stage receives fewer nibbles; leading zeros do not change the mod-5 result.
- Not defined: every word emits exactly N nibbles.

## Structure
- Shared package div_by_five_pkg:
  - NIBBLE_W=4.
  - Serializer state enum {IDLE, SEND}.
  - Function computing nibble count from BIT_WIDTH, reused by the downstream datapath.
- Flat module with no sub-module: one FSM, one counter, one shift register.

## Test plan
- BIT_WIDTH=32, macro off, in_msg=0x0000_0019, out_rdy=1 -> nibbles 9,1,0,0,0,0,0,0 on cycles t+1..t+8; first on 9, last on the 8th; in_rdy high on the 8th.
- Same stimulus, macro on -> nibbles 9,1 only, last on 1; in_msg=0 -> single nibble 0 with first=last=1.
- Backpressure: in_msg=0x8765_4321, out_rdy toggling 1,0,0,1,... -> nibble sequence 1..8 unchanged, values held stable during stalls, no drops or duplicates.
- Back-to-back: in_val held high with words 0x1111_1111 then 0x2222_2222 -> 16 consecutive out transfers with no bubble; the second first-flag follows the first last-flag directly.
- Reset after the 3rd nibble of 0xABCD_EF01 -> out_val=0 next cycle, in_rdy=1 after rst falls; the next word 0x5 emits starting from nibble 5.
- Idle: in_val=0 for 10 cycles -> out_val stays 0, in_rdy stays 1.
